// File: rtl/counter_cmd_scheduler.sv
// Command scheduler for a counter front panel. Button pulses and UART
// command bytes control run/stop, clear and count direction; the 'S'
// command snapshots the counter and transmits it as four ASCII decimal
// digits followed by CR LF.
module counter_cmd_scheduler #(
  parameter int COUNT_W  = 14,
  parameter int CONV_CYC = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_enable,
  input  logic               btn_clear,
  input  logic               btn_mode,
  input  logic [7:0]         rx_data,
  input  logic               rx_done,
  input  logic [COUNT_W-1:0] count,
  input  logic               tx_busy,
  output logic               enable,
  output logic               clear,
  output logic               mode,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  output logic               cmd_err
);

  typedef enum logic [2:0] {
    IDLE, SNAP, CONV, SEND, WAIT_HI, WAIT_LO
  } state_t;

  localparam int                 CYC_W    = $clog2(CONV_CYC + 1);
  localparam logic [CYC_W-1:0]   CYC_LAST = CYC_W'(CONV_CYC - 1);
  localparam logic [COUNT_W-1:0] SAT_MAX  = COUNT_W'(9999);

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] snap_q, snap_d;
  logic [15:0]        bcd_q, bcd_d;
  logic [15:0]        bcd_adj;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [2:0]         idx_q, idx_d;
  logic               enable_q, enable_d;
  logic               mode_q, mode_d;
  logic               clear_q, clear_d;
  logic               cmd_err_q, cmd_err_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic [7:0]         rpt_byte;
  logic               is_run, is_clr, is_mode, is_rpt, is_bad;

  // Decode the received byte; letters are accepted in either case.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
    is_run  = 1'b0;
    is_clr  = 1'b0;
    is_mode = 1'b0;
    is_rpt  = 1'b0;
    is_bad  = 1'b0;
    if (rx_done) begin
      unique case (rx_data)
        8'h52, 8'h72: is_run  = 1'b1;
        8'h43, 8'h63: is_clr  = 1'b1;
        8'h4D, 8'h6D: is_mode = 1'b1;
        8'h53, 8'h73: is_rpt  = 1'b1;
        default:      is_bad  = 1'b1;
      endcase
    end
  end

  // Control outputs: an OR of button and UART request yields a single toggle/pulse.
  always_comb begin
    enable_d  = enable_q ^ (btn_enable | is_run);
    mode_d    = mode_q ^ (btn_mode | is_mode);
    clear_d   = btn_clear | is_clr;
    cmd_err_d = is_bad | (is_rpt & (state_q != IDLE));
  end

  // Report byte selected by the current byte index.
  always_comb begin
    unique case (idx_q)
      3'd0:    rpt_byte = {4'h3, bcd_q[15:12]};
      3'd1:    rpt_byte = {4'h3, bcd_q[11:8]};
      3'd2:    rpt_byte = {4'h3, bcd_q[7:4]};
      3'd3:    rpt_byte = {4'h3, bcd_q[3:0]};
      3'd4:    rpt_byte = 8'h0D;
      default: rpt_byte = 8'h0A;
    endcase
  end

  // Report FSM: snapshot, double-dabble conversion, then a six-byte handshake with the UART.
  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    bcd_d      = bcd_q;
    cyc_d      = cyc_q;
    idx_d      = idx_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    bcd_adj    = bcd_q;
    unique case (state_q)
      IDLE: begin
        if (is_rpt) state_d = SNAP;
      end
      SNAP: begin
        snap_d  = (count > SAT_MAX) ? SAT_MAX : count;
        bcd_d   = '0;
        cyc_d   = '0;
        state_d = CONV;
      end
      CONV: begin
        // Add 3 to any digit >= 5 before the shift so it carries correctly into the next digit.
        for (int i = 0; i < 4; i++) begin
          if (bcd_adj[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_adj[4*i +: 4] + 4'd3;
        end
        {bcd_d, snap_d} = {bcd_adj[14:0], snap_q, 1'b0};
        cyc_d = cyc_q + 1'b1;
        if (cyc_q == CYC_LAST) begin
          idx_d   = 3'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_start_d = 1'b1;
          tx_data_d  = rpt_byte;
          state_d    = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy) state_d = WAIT_LO;
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (idx_q == 3'd5) begin
            idx_d   = 3'd0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any report in progress.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state_q    <= IDLE;
      snap_q     <= '0;
      bcd_q      <= '0;
      cyc_q      <= '0;
      idx_q      <= '0;
      enable_q   <= 1'b0;
      mode_q     <= 1'b0;
      clear_q    <= 1'b0;
      cmd_err_q  <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      snap_q     <= snap_d;
      bcd_q      <= bcd_d;
      cyc_q      <= cyc_d;
      idx_q      <= idx_d;
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      clear_q    <= clear_d;
      cmd_err_q  <= cmd_err_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign enable   = enable_q;
  assign mode     = mode_q;
  assign clear    = clear_q;
  assign cmd_err  = cmd_err_q;
  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;

endmodule
